// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci term path: term width, saturation
// value and the default {term, idx} entry layout used by consumers.
package fib_pkg;
  localparam int          FIB_W       = 32;
  localparam logic [31:0] FIB_SAT_VAL = 32'hFFFF_FFFF;
  localparam int          FIB_IDX_W   = 16;

  typedef struct packed {
    logic [FIB_W-1:0]     term;
    logic [FIB_IDX_W-1:0] idx;
  } fib_entry_t;
endpackage

// File: rtl/fib_fwft_fifo.sv
// First-word-fall-through circular FIFO. rdata shows the head entry
// combinationally and reads as zero while empty. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module fib_fwft_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  // Status flags, accepted operations and next pointer/count values.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so no stale entry is ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !clr) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Head entry falls through; zero while empty.
  always_comb begin
    rdata = empty ? '0 : mem_q[rd_ptr_q];
  end
endmodule

// File: rtl/fib_term_buffer.sv
// Buffers terms from the 32-bit Fibonacci generator into a FWFT FIFO and
// streams them out tagged with their sequence index. Tracks 32-bit wrap of
// the sequence (sticky overflow) and a saturating count of dropped terms.
// Build option FIB_TERM_BUFFER_SAT_EN: once overflow is set, or is being set
// by the current capture, stored terms are replaced by FIB_SAT_VAL.
module fib_term_buffer
  import fib_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              term_en,
  input  logic [FIB_W-1:0]  fib_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [FIB_W-1:0]  out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              full,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);
  localparam int EW = FIB_W + IDX_W;

  logic              cap_pend_q, cap_pend_d;
  logic [IDX_W-1:0]  next_idx_q, next_idx_d;
  logic [FIB_W-1:0]  prev_term_q, prev_term_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              push, pop, ovf_hit;
  logic [FIB_W-1:0]  store_term;
  logic              fifo_empty, fifo_full;
  logic [EW-1:0]     fifo_rdata;

  // Capture, index, wrap detection and drop accounting; clr wins over all.
  always_comb begin
    push    = cap_pend_q;
    pop     = !fifo_empty && out_ready;
    ovf_hit = cap_pend_q && (next_idx_q >= IDX_W'(2)) && (fib_in < prev_term_q);
`ifdef FIB_TERM_BUFFER_SAT_EN
    store_term = (overflow_q || ovf_hit) ? FIB_SAT_VAL : fib_in;
`else
    store_term = fib_in;
`endif
    cap_pend_d  = term_en;
    next_idx_d  = next_idx_q;
    prev_term_d = prev_term_q;
    overflow_d  = overflow_q || ovf_hit;
    drop_d      = drop_q;
    if (push) begin
      next_idx_d  = next_idx_q + IDX_W'(1);
      prev_term_d = fib_in;
      if (fifo_full && !pop && (drop_q != {DROP_W{1'b1}}))
        drop_d = drop_q + DROP_W'(1);
    end
    if (clr) begin
      cap_pend_d  = 1'b0;
      next_idx_d  = '0;
      prev_term_d = '0;
      overflow_d  = 1'b0;
      drop_d      = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_pend_q  <= 1'b0;
      next_idx_q  <= '0;
      prev_term_q <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      cap_pend_q  <= cap_pend_d;
      next_idx_q  <= next_idx_d;
      prev_term_q <= prev_term_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  fib_fwft_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata ({store_term, next_idx_q}),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Output stream and status.
  always_comb begin
    out_valid  = !fifo_empty;
    out_data   = fifo_rdata[EW-1:IDX_W];
    out_index  = fifo_rdata[IDX_W-1:0];
    full       = fifo_full;
    overflow   = overflow_q;
    drop_count = drop_q;
  end
endmodule

// File: tb/tb_fib_term_buffer.sv
// Directed bench for fib_term_buffer with a behavioural Fibonacci generator.
module tb_fib_term_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        term_en = 1'b0;
  logic [31:0] fib_in;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [15:0] out_index;
  logic        full;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fib_tab [0:13] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8,
                                  32'd13, 32'd21, 32'd34, 32'd55, 32'd89, 32'd144, 32'd233};

  // Generator model: fib_out takes the next term on each edge with start=1.
  logic [31:0] gen_a, gen_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_a <= 32'd0; gen_b <= 32'd1; fib_in <= 32'd0;
    end else if (term_en) begin
      fib_in <= gen_a; gen_a <= gen_b; gen_b <= gen_a + gen_b;
    end
  end

  always #5 clk = ~clk;

  fib_term_buffer #(.DEPTH(8), .IDX_W(16), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .term_en(term_en), .fib_in(fib_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .full(full), .overflow(overflow), .drop_count(drop_count)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    term_en = 1'b0; clr = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0d want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
    n_cmp++; if (out_index !== 16'd0) begin n_bad++; $display("FAIL reset_index: got %0d want 0", out_index); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %0d want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %0d want 0", overflow); end
    n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid: got %0d want 0", out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    term_en = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 10) term_en = 1'b0;
      if (e == 1 || e == 12) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_valid_e%0d: got %0d want 0", e, out_valid); end
      end else begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid_e%0d: got %0d want 1", e, out_valid); end
        n_cmp++; if (out_data !== fib_tab[e-2]) begin n_bad++; $display("FAIL stream_data_e%0d: got %0d want %0d", e, out_data, fib_tab[e-2]); end
        n_cmp++; if (out_index !== 16'(e-2)) begin n_bad++; $display("FAIL stream_index_e%0d: got %0d want %0d", e, out_index, e-2); end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_drop();
    do_reset();
    term_en = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      step();
      if (e == 12) term_en = 1'b0;
      if (e == 8) begin
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_at7: got %0d want 0", full); end
      end
      if (e == 9) begin
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_at8: got %0d want 1", full); end
        n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL drop_at8: got %0d want 0", drop_count); end
      end
    end
    n_cmp++; if (drop_count !== 8'd4) begin n_bad++; $display("FAIL drop_after12: got %0d want 4", drop_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_index !== 16'(i)) begin n_bad++; $display("FAIL drain_index%0d: got %0d want %0d", i, out_index, i); end
      n_cmp++; if (out_data !== fib_tab[i]) begin n_bad++; $display("FAIL drain_data%0d: got %0d want %0d", i, out_data, fib_tab[i]); end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %0d want 0", out_valid); end
    term_en = 1'b1;
    step();
    term_en = 1'b0;
    step();
    n_cmp++; if (out_index !== 16'd12) begin n_bad++; $display("FAIL next_index: got %0d want 12", out_index); end
    n_cmp++; if (out_data !== 32'd144) begin n_bad++; $display("FAIL next_data: got %0d want 144", out_data); end
  endtask

  // Continues from test_full_drop: one entry (index 12) queued, drop_count=4.
  task automatic test_back_to_back();
    term_en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 7) term_en = 1'b0;
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL b2b_full_before: got %0d want 1", full); end
    term_en = 1'b1;
    step();
    term_en = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL b2b_full_after: got %0d want 1", full); end
    n_cmp++; if (drop_count !== 8'd4) begin n_bad++; $display("FAIL b2b_drop: got %0d want 4", drop_count); end
    n_cmp++; if (out_index !== 16'd13) begin n_bad++; $display("FAIL b2b_head_index: got %0d want 13", out_index); end
    n_cmp++; if (out_data !== 32'd233) begin n_bad++; $display("FAIL b2b_head_data: got %0d want 233", out_data); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp48;
`ifdef FIB_TERM_BUFFER_SAT_EN
    exp48 = 32'hFFFF_FFFF;
`else
    exp48 = 32'd512559680;
`endif
    do_reset();
    term_en = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 51; e++) begin
      step();
      if (e == 49) begin
        term_en = 1'b0;
        n_cmp++; if (out_data !== 32'd2971215073) begin n_bad++; $display("FAIL ovf_term47: got %0d want 2971215073", out_data); end
        n_cmp++; if (out_index !== 16'd47) begin n_bad++; $display("FAIL ovf_index47: got %0d want 47", out_index); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %0d want 0", overflow); end
      end
      if (e == 50) begin
        n_cmp++; if (out_data !== exp48) begin n_bad++; $display("FAIL ovf_term48: got %0d want %0d", out_data, exp48); end
        n_cmp++; if (out_index !== 16'd48) begin n_bad++; $display("FAIL ovf_index48: got %0d want 48", out_index); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0d want 1", overflow); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0d want 1", overflow); end
    out_ready = 1'b0;
  endtask

  // Continues from test_overflow: overflow=1, FIFO empty.
  task automatic test_clr();
    term_en = 1'b1;
    for (int e = 1; e <= 11; e++) step();
    n_cmp++; if (drop_count !== 8'd2) begin n_bad++; $display("FAIL clr_pre_drop: got %0d want 2", drop_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL clr_pre_ovf: got %0d want 1", overflow); end
    clr = 1'b1; term_en = 1'b0;
    step();
    clr = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %0d want 0", out_valid); end
    n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL clr_drop: got %0d want 0", drop_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf: got %0d want 0", overflow); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL clr_full: got %0d want 0", full); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_pending_discard: got %0d want 0", out_valid); end
    term_en = 1'b1;
    step();
    term_en = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_next_valid: got %0d want 1", out_valid); end
    n_cmp++; if (out_index !== 16'd0) begin n_bad++; $display("FAIL clr_next_index: got %0d want 0", out_index); end
  endtask

  task automatic test_async_rst();
    do_reset();
    term_en = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 5; e++) step();
    n_cmp++; if (out_index !== 16'd3) begin n_bad++; $display("FAIL arst_pre_index: got %0d want 3", out_index); end
    n_cmp++; if (out_data !== 32'd2) begin n_bad++; $display("FAIL arst_pre_data: got %0d want 2", out_data); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %0d want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL arst_data: got %0d want 0", out_data); end
    n_cmp++; if (out_index !== 16'd0) begin n_bad++; $display("FAIL arst_index: got %0d want 0", out_index); end
    #1 rst = 1'b0;
    out_ready = 1'b0;
    step();
    term_en = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL arst_resume_valid: got %0d want 1", out_valid); end
    n_cmp++; if (out_index !== 16'd0) begin n_bad++; $display("FAIL arst_resume_index: got %0d want 0", out_index); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL arst_resume_data: got %0d want 0", out_data); end
    step();
    n_cmp++; if (out_index !== 16'd0) begin n_bad++; $display("FAIL arst_single_entry: got %0d want 0", out_index); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_drop();
    test_back_to_back();
    test_overflow();
    test_clr();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
